aes_key_schedule_seq: RTL and testbench

Sequential, area-reduced AES key expansion for all key sizes (128, 192 and 256 bits), selected by parameter. It generates one 32-bit schedule word per cycle into an internal word store. The cipher datapath then reads whole 128-bit round keys by round index. An optional read mode supplies the Equivalent Inverse Cipher decryption keys with InvMixColumns applied. It sits between key-load logic and an iterative AES round engine, and replaces the fully unrolled combinational expansion where area matters.

---
 rtl/aes_key_schedule_seq_pkg.sv | 100 ++++++++++
 rtl/aes_key_schedule_seq_word_step.sv | 21 ++
 rtl/aes_key_schedule_seq.sv | 131 +++++++++++++
 tb/tb_aes_key_schedule_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_schedule_seq_pkg.sv
// Shared types and GF(2^8) helpers for the sequential AES key schedule.
// The S-box is built from field inversion plus the affine map, so no 256-entry table is needed.
package aes_key_schedule_seq_pkg;

  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PH_ROT   = 2'd0,
    PH_SUB   = 2'd1,
    PH_PLAIN = 2'd2
  } phase_t;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic bit nk_legal(int nk);
    return (nk == NK_128) || (nk == NK_192) || (nk == NK_256);
  endfunction

  function automatic logic [7:0] rcon_at(int idx);
    return (idx >= 0 && idx < 10) ? RCON[idx] : 8'h00;
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] gf_inv(logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] inv_mix_col(logic [31:0] w);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      a[k]  = w[31-8*k -: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[31-8*k -: 8] = me[k] ^ mb[(k+1)%4] ^ md[(k+2)%4] ^ m9[(k+3)%4];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_schedule_seq_word_step.sv
// One key-expansion step: combines w[i-NK] with the transformed w[i-1].
module aes_key_schedule_seq_word_step
  import aes_key_schedule_seq_pkg::*;
(
  input  logic [31:0] i_w_im_nk,
  input  logic [31:0] i_w_i_minus_1,
  input  logic [7:0]  i_rcon,
  input  phase_t      i_phase,
  output logic [31:0] o_word
);

  always_comb begin
    o_word = i_w_im_nk ^ i_w_i_minus_1;
    case (i_phase)
      PH_ROT:   o_word = i_w_im_nk ^ sub_word(rot_word(i_w_i_minus_1)) ^ {i_rcon, 24'h0};
      PH_SUB:   o_word = i_w_im_nk ^ sub_word(i_w_i_minus_1);
      default:  o_word = i_w_im_nk ^ i_w_i_minus_1;
    endcase
  end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES key expansion, one schedule word per clock, with round-key read port.
// state    | meaning
// S_IDLE   | no schedule held, key accepted
// S_EXPAND | generating w[NK..NW-1], one word per cycle
// S_DONE   | schedule complete and readable, new key accepted
module aes_key_schedule_seq
  import aes_key_schedule_seq_pkg::*;
#(
  parameter  int NK = 4,
  localparam int NR = NK + 6,
  localparam int NW = 4 * (NR + 1),
  localparam int RW = $clog2(NR + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_key_valid,
  output logic              o_key_ready,
  input  logic [32*NK-1:0]  i_key,
  output logic              o_busy,
  output logic              o_rk_valid,
  input  logic [RW-1:0]     i_rd_round,
  input  logic              i_rd_inv,
  output logic [127:0]      o_rd_rkey
);

  localparam int CW = $clog2(NW);

  if (!nk_legal(NK)) begin : g_bad_nk
    $error("aes_key_schedule_seq: NK must be 4, 6 or 8");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NW-1:0][31:0]  r_w;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_pos;
  logic [7:0]           r_rcon;
  logic                 w_accept;
  phase_t               w_phase;
  logic [31:0]          w_next;
  logic [CW-1:0]        w_base;
  logic                 w_inv;
  logic [31:0]          w_wd;

  assign w_accept = i_key_valid & o_key_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_key_valid) w_state_nxt = S_EXPAND;
      S_EXPAND: if (r_cnt == CW'(NW - 1)) w_state_nxt = S_DONE;
      S_DONE:   if (i_key_valid) w_state_nxt = S_EXPAND;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_key_ready = 1'b0;
    o_busy      = 1'b0;
    o_rk_valid  = 1'b0;
    case (r_state)
      S_IDLE:   o_key_ready = 1'b1;
      S_EXPAND: o_busy      = 1'b1;
      S_DONE: begin
        o_key_ready = 1'b1;
        o_rk_valid  = 1'b1;
      end
      default:  o_key_ready = 1'b0;
    endcase
  end

  // r_pos tracks i mod NK so no divider is needed for the 192-bit case
  always_comb begin
    if (r_pos == 3'd0)                  w_phase = PH_ROT;
    else if (NK == 8 && r_pos == 3'd4)  w_phase = PH_SUB;
    else                                w_phase = PH_PLAIN;
  end

  aes_key_schedule_seq_word_step u_step (
    .i_w_im_nk     (r_w[r_cnt - CW'(NK)]),
    .i_w_i_minus_1 (r_w[r_cnt - CW'(1)]),
    .i_rcon        (r_rcon),
    .i_phase       (w_phase),
    .o_word        (w_next)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_w    <= '0;
      r_cnt  <= '0;
      r_pos  <= '0;
      r_rcon <= 8'h01;
    end else if (w_accept) begin
      for (int k = 0; k < NK; k++) r_w[k] <= i_key[32*k +: 32];
      r_cnt  <= CW'(NK);
      r_pos  <= '0;
      r_rcon <= 8'h01;
    end else if (r_state == S_EXPAND) begin
      r_w[r_cnt] <= w_next;
      r_cnt      <= r_cnt + CW'(1);
      r_pos      <= (r_pos == 3'(NK - 1)) ? 3'd0 : r_pos + 3'd1;
      if (w_phase == PH_ROT) r_rcon <= xtime(r_rcon);
    end
  end

  assign w_base = CW'({i_rd_round, 2'b00});
  assign w_inv  = i_rd_inv && (i_rd_round != '0) && (i_rd_round < RW'(NR));

  always_comb begin
    o_rd_rkey = '0;
    w_wd      = '0;
    if (i_rd_round <= RW'(NR)) begin
      for (int j = 0; j < 4; j++) begin
        w_wd = r_w[w_base + CW'(j)];
        if (w_inv) w_wd = inv_mix_col(w_wd);
        o_rd_rkey[32*j +: 32] = w_wd;
      end
    end
  end

  a_rcon_matches_table: assert property (
    @(posedge i_clk) disable iff (!i_reset_n)
    (r_state == S_EXPAND && w_phase == PH_ROT) |-> (r_rcon == rcon_at(int'(r_cnt) / NK - 1))
  );

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Scoreboard bench for aes_key_schedule_seq at NK=4, 6 and 8 against a FIPS-197 style reference model.
module tb_aes_key_schedule_seq;

  typedef struct packed {
    logic [1:0]        dut;
    logic              full;
    logic [1:0]        nkv;
    logic [2:0][5:0]   kidx;
    logic [2:0][31:0]  kval;
    logic [255:0]      key;
  } item_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   key_valid_v = 3'b000;
  logic [2:0]   key_ready_v;
  logic [2:0]   busy_v;
  logic [2:0]   rk_valid_v;
  logic [255:0] key_bus = '0;
  int           n_checks = 0;
  int           n_pass = 0;
  item_t        sb_q[$];
  logic [7:0]   sbox_t [256];

  always #5 clk = ~clk;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] t_sub(logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [31:0] model_word(int nk, logic [255:0] key, int idx);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = t_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = t_sub(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return w[idx];
  endfunction

  function automatic logic [31:0] inv_mix_tb(logic [31:0] wd);
    logic [7:0]  a [4];
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++) a[k] = wd[31-8*k -: 8];
    for (int k = 0; k < 4; k++)
      r[31-8*k -: 8] = gmul(a[k], 8'h0e) ^ gmul(a[(k+1)%4], 8'h0b) ^
                       gmul(a[(k+2)%4], 8'h0d) ^ gmul(a[(k+3)%4], 8'h09);
    return r;
  endfunction

  function automatic logic [127:0] exp_rkey(int nk, logic [255:0] key, int r, int inv);
    logic [127:0] res = '0;
    logic [31:0]  wd;
    int           nr = nk + 6;
    if (r > nr) return '0;
    for (int j = 0; j < 4; j++) begin
      wd = model_word(nk, key, 4*r + j);
      if (inv != 0 && r >= 1 && r < nr) wd = inv_mix_tb(wd);
      res[32*j +: 32] = wd;
    end
    return res;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NKG = 4 + 2*g;
    localparam int NRG = NKG + 6;
    logic [3:0]   rd_round = 4'd0;
    logic         rd_inv = 1'b0;
    logic [127:0] rkey;
    int           n_done = 0;

    aes_key_schedule_seq #(.NK(NKG)) u_dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_key_valid (key_valid_v[g]),
      .o_key_ready (key_ready_v[g]),
      .i_key       (key_bus[32*NKG-1:0]),
      .o_busy      (busy_v[g]),
      .o_rk_valid  (rk_valid_v[g]),
      .i_rd_round  (rd_round),
      .i_rd_inv    (rd_inv),
      .o_rd_rkey   (rkey)
    );

    initial begin : monitor
      bit    pending;
      bit    counting;
      int    edges;
      int    jw;
      item_t it;
      pending  = 1'b0;
      counting = 1'b0;
      edges    = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          pending  = 1'b0;
          counting = 1'b0;
        end else begin
          if (pending) begin
            edges    = 1;
            counting = 1'b1;
            pending  = 1'b0;
            chk($sformatf("dut%0d post_accept {rk_valid,busy,key_ready}", g),
                128'({rk_valid_v[g], busy_v[g], key_ready_v[g]}), 128'(3'b010));
          end else if (counting) begin
            edges++;
          end
          if (counting && rk_valid_v[g]) begin
            counting = 1'b0;
            if (sb_q.size() == 0) begin
              chk($sformatf("dut%0d scoreboard_depth", g), 128'(sb_q.size()), 128'(1));
            end else begin
              it = sb_q.pop_front();
              chk($sformatf("dut%0d sb_dut", g), 128'(it.dut), 128'(g));
              chk($sformatf("dut%0d latency", g), 128'(edges), 128'(4*(NRG+1) - NKG + 1));
              chk($sformatf("dut%0d done {busy,key_ready}", g),
                  128'({busy_v[g], key_ready_v[g]}), 128'(2'b01));
              if (it.full) begin
                for (int r = 0; r <= NRG + 1; r++) begin
                  for (int inv = 0; inv < 2; inv++) begin
                    @(negedge clk);
                    rd_round = 4'(r);
                    rd_inv   = (inv != 0);
                    #2;
                    chk($sformatf("dut%0d rkey r%0d inv%0d", g, r, inv), rkey,
                        exp_rkey(NKG, it.key, r, inv));
                  end
                end
                for (int k = 0; k < 3; k++) begin
                  if (k < int'(it.nkv)) begin
                    @(negedge clk);
                    rd_round = 4'(it.kidx[k] >> 2);
                    rd_inv   = 1'b0;
                    #2;
                    jw = int'(it.kidx[k][1:0]);
                    chk($sformatf("dut%0d known w[%0d]", g, it.kidx[k]),
                        128'(rkey[32*jw +: 32]), 128'(it.kval[k]));
                  end
                end
                rd_round = 4'd0;
                rd_inv   = 1'b0;
              end
              n_done++;
            end
          end
          pending = key_valid_v[g] && key_ready_v[g];
        end
      end
    end
  end

  function automatic int get_done(int g);
    case (g)
      0:       return g_dut[0].n_done;
      1:       return g_dut[1].n_done;
      default: return g_dut[2].n_done;
    endcase
  endfunction

  function automatic item_t mk(int g, logic [255:0] key, bit full);
    item_t it = '0;
    it.dut  = 2'(g);
    it.full = full;
    it.key  = key;
    return it;
  endfunction

  task automatic wait_accept(int g);
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (key_ready_v[g]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #2;
    chk($sformatf("dut%0d accept_wait", g), 128'(ok), 128'(1));
  endtask

  task automatic issue(item_t it);
    @(posedge clk);
    #2;
    key_bus = it.key;
    key_valid_v[it.dut] = 1'b1;
    sb_q.push_back(it);
    wait_accept(int'(it.dut));
    key_valid_v[it.dut] = 1'b0;
  endtask

  task automatic wait_done(int g, int target);
    bit ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      #3;
      if (get_done(g) >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("dut%0d done_wait", g), 128'(ok), 128'(1));
  endtask

  task automatic run(item_t it);
    int prev;
    prev = get_done(int'(it.dut));
    issue(it);
    wait_done(int'(it.dut), prev + 1);
  endtask

  localparam logic [255:0] KEY4 = 256'({32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516});
  localparam logic [255:0] KEY6 = 256'({32'h522c6b7b, 32'h62f8ead2, 32'h809079e5,
                                        32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7});
  localparam logic [255:0] KEY8 = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                                   32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};

  function automatic item_t fips4();
    item_t it = mk(0, KEY4, 1'b1);
    it.nkv = 2'd3;
    it.kidx[0] = 6'd4;  it.kval[0] = 32'ha0fafe17;
    it.kidx[1] = 6'd40; it.kval[1] = 32'hd014f9a8;
    it.kidx[2] = 6'd43; it.kval[2] = 32'hb6630ca6;
    return it;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    item_t it;
    item_t it_b;
    int    prev;
    logic [7:0] p, q, x;

    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;

    #3;
    chk("reset key_ready", 128'(key_ready_v), 128'(3'b111));
    chk("reset busy", 128'(busy_v), 128'(3'b000));
    chk("reset rk_valid", 128'(rk_valid_v), 128'(3'b000));
    chk("reset store dut0 r0", g_dut[0].rkey, 128'h0);
    chk("reset store dut2 r0", g_dut[2].rkey, 128'h0);
    #10;
    rst_n = 1'b1;

    run(fips4());

    it = mk(1, KEY6, 1'b1);
    it.nkv = 2'd2;
    it.kidx[0] = 6'd6;  it.kval[0] = 32'hfe0c91f7;
    it.kidx[1] = 6'd51; it.kval[1] = 32'h01002202;
    run(it);

    it = mk(2, KEY8, 1'b1);
    it.nkv = 2'd3;
    it.kidx[0] = 6'd8;  it.kval[0] = 32'h9ba35411;
    it.kidx[1] = 6'd12; it.kval[1] = 32'ha8b09c1a;
    it.kidx[2] = 6'd59; it.kval[2] = 32'h706c631e;
    run(it);

    for (int rep = 0; rep < 2; rep++)
      for (int g = 0; g < 3; g++)
        run(mk(g, {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()}, 1'b1));

    // second key held through EXPAND must wait for DONE
    prev = get_done(0);
    it   = mk(0, {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
    it_b = fips4();
    @(posedge clk);
    #2;
    key_bus = it.key;
    key_valid_v[0] = 1'b1;
    sb_q.push_back(it);
    wait_accept(0);
    key_bus = it_b.key;
    sb_q.push_back(it_b);
    wait_accept(0);
    key_valid_v[0] = 1'b0;
    wait_done(0, prev + 2);

    // asynchronous reset in the middle of an expansion
    issue(fips4());
    repeat (19) @(posedge clk);
    #3;
    chk("mid_expand busy", 128'({busy_v[0], rk_valid_v[0]}), 128'(2'b10));
    chk("mid_expand partial r0", g_dut[0].rkey, KEY4[127:0]);
    rst_n = 1'b0;
    #1;
    chk("async_reset {key_ready,busy,rk_valid}",
        128'({key_ready_v[0], busy_v[0], rk_valid_v[0]}), 128'(3'b100));
    chk("async_reset store r0", g_dut[0].rkey, 128'h0);
    sb_q.delete();
    #10;
    rst_n = 1'b1;
    run(fips4());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
